stb_read_mux: RTL
=================

STB_READ_MUX -- requirements
Module: stb_read_mux

Parameters
REQ-001 SHALL have parameter NUM_STB, default 2; number of STB channels, legal range 1..8.
REQ-002 SHALL have parameter STATUS_WIDTH, default 8; width of each STB status word.
REQ-003 SHALL have parameter DATA_WIDTH, default 32; width of each STB data word.
REQ-004 SHALL have parameter READ_WIDTH, default 41; width of the TAP read word; at least max(STATUS_WIDTH, DATA_WIDTH).
REQ-005 SHALL have parameter IRLENGTH, default 5; TAP address width.
REQ-006 SHALL have parameter DMI_ADDR, default 5'h11; TAP address of the DMI source.
REQ-007 SHALL have parameter STB_BASE, default 5'h18; channel k status at STB_BASE+2k, data at STB_BASE+2k+1.
REQ-008 SHALL have parameter TIMEOUT_CYCLES, default 1023; WAIT cycle limit, 0 disables the timeout.

Interface
REQ-009 CLK_I  in  1  sole clock; all logic on rising edge.
REQ-010 RST_I  in  1  reset; synchronous, active-high.
REQ-011 READ_ADDRESS_I  in  IRLENGTH  TAP read address, sampled at request start.
REQ-012 READ_READY_I  in  1  TAP request/accept strobe.
REQ-013 READ_VALID_O  out  1  read word available.
REQ-014 READ_DATA_O  out  READ_WIDTH  read word.
REQ-015 READ_ERROR_O  out  1  qualifies READ_VALID_O: unmapped address or timeout.
REQ-016 ADDR_VALID_O  out  1  captured address is mapped.
REQ-017 DMI_READ_READY_O / DMI_READ_VALID_I / DMI_READ_DATA_I  out/in/in  1/1/READ_WIDTH  DMI source handshake.
REQ-018 STB_STATUS_READY_O / STB_STATUS_VALID_I  out/in  NUM_STB each  per-channel status handshake, bit k = channel k.
REQ-019 STB_STATUS_I  in  NUM_STB*STATUS_WIDTH  flattened status, channel k at [k*STATUS_WIDTH +: STATUS_WIDTH].
REQ-020 STB_DATA_READY_O / STB_DATA_VALID_I  out/in  NUM_STB each  per-channel data handshake.
REQ-021 STB_DATA_I  in  NUM_STB*DATA_WIDTH  flattened data, channel k at [k*DATA_WIDTH +: DATA_WIDTH].

Function
REQ-022 SHALL implement an FSM with states IDLE, WAIT and HOLD.
REQ-023 IDLE: when READ_READY_I=1, SHALL register READ_ADDRESS_I, decode it and go to WAIT next cycle.
REQ-024 SHALL register ADDR_VALID_O on request start; it holds until return to IDLE, then clears.
REQ-025 Unmapped address in IDLE: SHALL skip WAIT, go to HOLD with data all-zero and READ_ERROR_O=1.
REQ-026 WAIT: SHALL assert exactly the selected source's ready, all other source readies 0; no ready in IDLE/HOLD.
REQ-027 WAIT, selected valid=1: SHALL capture data and go to HOLD next cycle.
REQ-028 Captured STB data SHALL be zero-extended to READ_WIDTH; DMI data passes unmodified.
REQ-029 Minimum latency: request in cycle n, source valid already high, gives READ_VALID_O=1 in cycle n+2.
REQ-030 Timeout counter SHALL clear on WAIT entry and increment each WAIT cycle.
REQ-031 Timeout: when the counter reaches TIMEOUT_CYCLES without valid, SHALL drop ready, go to HOLD with data all-ones and READ_ERROR_O=1.
REQ-032 Valid in the same cycle the counter reaches the limit: SHALL take valid, no error.
REQ-033 HOLD: READ_VALID_O=1 with READ_DATA_O/READ_ERROR_O stable; leaves to IDLE on the cycle READ_READY_I=1.
REQ-034 READ_READY_I held high: SHALL start a new request one cycle after the HOLD handshake.
REQ-035 Source valid outside WAIT, or on unselected channels, SHALL be ignored.

Reset
REQ-036 RST_I=1 at a clock edge SHALL force IDLE and clear the timeout counter.
REQ-037 At the same edge SHALL set READ_VALID_O, READ_ERROR_O, ADDR_VALID_O, READ_DATA_O and all source readies to 0, including mid-WAIT/HOLD; no partial transaction resumes.

Verification
REQ-038 NUM_STB=2, addr 5'h1B, STB_DATA_VALID_I[1]=1, data 32'hDEADBEEF -> READ_VALID_O at n+2, READ_DATA_O=41'h0DEADBEEF, error 0.
REQ-039 Addr 5'h11, DMI valid delayed 5 cycles -> DMI_READ_READY_O high 5 WAIT cycles only, then data, error 0.
REQ-040 Addr 5'h05 -> ADDR_VALID_O=0, HOLD at n+1, data 0, READ_ERROR_O=1, no source ready ever asserted.
REQ-041 TIMEOUT_CYCLES=4, addr 5'h18, no valid -> ready exactly 4 cycles, data all-ones, READ_ERROR_O=1.
REQ-042 RST_I pulse during WAIT on 5'h19 -> next edge all outputs 0, IDLE.
REQ-043 READ_READY_I held high across two back-to-back reads of 5'h18 then 5'h1A -> each read served in order with correct channel data.

Source files
------------

// File: rtl/stb_read_mux.sv
// Read multiplexer: routes a TAP read request to the DMI source or to one STB
// channel's status/data word, and returns the word with an error qualifier.
module stb_read_mux #(
  parameter int                  NUM_STB        = 2,
  parameter int                  STATUS_WIDTH   = 8,
  parameter int                  DATA_WIDTH     = 32,
  parameter int                  READ_WIDTH     = 41,
  parameter int                  IRLENGTH       = 5,
  parameter logic [IRLENGTH-1:0] DMI_ADDR       = 5'h11,
  parameter logic [IRLENGTH-1:0] STB_BASE       = 5'h18,
  parameter int                  TIMEOUT_CYCLES = 1023
) (
  input  logic                             CLK_I,
  input  logic                             RST_I,
  input  logic [IRLENGTH-1:0]              READ_ADDRESS_I,
  input  logic                             READ_READY_I,
  output logic                             READ_VALID_O,
  output logic [READ_WIDTH-1:0]            READ_DATA_O,
  output logic                             READ_ERROR_O,
  output logic                             ADDR_VALID_O,
  output logic                             DMI_READ_READY_O,
  input  logic                             DMI_READ_VALID_I,
  input  logic [READ_WIDTH-1:0]            DMI_READ_DATA_I,
  output logic [NUM_STB-1:0]               STB_STATUS_READY_O,
  input  logic [NUM_STB-1:0]               STB_STATUS_VALID_I,
  input  logic [NUM_STB*STATUS_WIDTH-1:0]  STB_STATUS_I,
  output logic [NUM_STB-1:0]               STB_DATA_READY_O,
  input  logic [NUM_STB-1:0]               STB_DATA_VALID_I,
  input  logic [NUM_STB*DATA_WIDTH-1:0]    STB_DATA_I
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // The counter only needs to reach TIMEOUT_CYCLES-1: the limit is detected one
  // cycle early so the last WAIT cycle can still accept a valid word.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [1:0]            state;
  logic [CNT_W-1:0]      wait_cnt;
  logic                  sel_dmi;
  logic [NUM_STB-1:0]    sel_status;
  logic [NUM_STB-1:0]    sel_data;

  logic                  dec_dmi;
  logic [NUM_STB-1:0]    dec_status;
  logic [NUM_STB-1:0]    dec_data;
  logic                  dec_mapped;
  logic                  sel_valid;
  logic [READ_WIDTH-1:0] sel_word;
  logic                  timeout_hit;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    dec_dmi    = (READ_ADDRESS_I == DMI_ADDR);
    dec_status = '0;
    dec_data   = '0;
    for (int k = 0; k < NUM_STB; k++) begin
      if (READ_ADDRESS_I == IRLENGTH'(STB_BASE + 2 * k))     dec_status[k] = 1'b1;
      if (READ_ADDRESS_I == IRLENGTH'(STB_BASE + 2 * k + 1)) dec_data[k]   = 1'b1;
    end
    dec_mapped = dec_dmi | (|dec_status) | (|dec_data);
  end

  // Selects are one-hot (or all-zero), so an OR-reduction is a valid mux.
  always_comb begin
    sel_valid = sel_dmi & DMI_READ_VALID_I;
    sel_word  = '0;
    if (sel_dmi) sel_word = DMI_READ_DATA_I;
    for (int k = 0; k < NUM_STB; k++) begin
      if (sel_status[k]) begin
        sel_valid = sel_valid | STB_STATUS_VALID_I[k];
        sel_word  = sel_word | READ_WIDTH'(STB_STATUS_I[k*STATUS_WIDTH +: STATUS_WIDTH]);
      end
      if (sel_data[k]) begin
        sel_valid = sel_valid | STB_DATA_VALID_I[k];
        sel_word  = sel_word | READ_WIDTH'(STB_DATA_I[k*DATA_WIDTH +: DATA_WIDTH]);
      end
    end
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  assign DMI_READ_READY_O   = (state == ST_WAIT) & sel_dmi;
  assign STB_STATUS_READY_O = (state == ST_WAIT) ? sel_status : '0;
  assign STB_DATA_READY_O   = (state == ST_WAIT) ? sel_data : '0;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      sel_dmi      <= 1'b0;
      sel_status   <= '0;
      sel_data     <= '0;
      READ_VALID_O <= 1'b0;
      READ_ERROR_O <= 1'b0;
      ADDR_VALID_O <= 1'b0;
      READ_DATA_O  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (READ_READY_I) begin
            sel_dmi      <= dec_dmi;
            sel_status   <= dec_status;
            sel_data     <= dec_data;
            ADDR_VALID_O <= dec_mapped;
            wait_cnt     <= '0;
            if (dec_mapped) begin
              state <= ST_WAIT;
            end else begin
              state        <= ST_HOLD;
              READ_VALID_O <= 1'b1;
              READ_ERROR_O <= 1'b1;
              READ_DATA_O  <= '0;
            end
          end
        end
        ST_WAIT: begin
          if (sel_valid) begin
            state        <= ST_HOLD;
            READ_VALID_O <= 1'b1;
            READ_ERROR_O <= 1'b0;
            READ_DATA_O  <= sel_word;
          end else if (timeout_hit) begin
            state        <= ST_HOLD;
            READ_VALID_O <= 1'b1;
            READ_ERROR_O <= 1'b1;
            READ_DATA_O  <= '1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (READ_READY_I) begin
            state        <= ST_IDLE;
            READ_VALID_O <= 1'b0;
            READ_ERROR_O <= 1'b0;
            ADDR_VALID_O <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
